// File: rtl/filter_ctrl_seq.sv
// filter_ctrl_seq: frame sequencer behind the 8-bit control PIO.
// It turns a start edge on ctrl_in[0] into one raster walk of IMG_W x IMG_H.
// The walk is issued as coordinate beats on a valid/ready handshake.
// A status byte reports busy, done, timeout, aborted and a frame count.
// Optional feature: define FILTER_CTRL_SEQ_TIMEOUT_EN to add a stall
// counter and an ERR state. The stall limit is TIMEOUT_CYCLES.
module filter_ctrl_seq #(
  parameter int IMG_W          = 640,
  parameter int IMG_H          = 480,
  parameter int X_W            = 10,
  parameter int Y_W            = 9,
  parameter int ADDR_W         = 19,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        ctrl_in,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [X_W-1:0]    pix_x,
  output logic [Y_W-1:0]    pix_y,
  output logic              pix_last,
  output logic [1:0]        pix_mode,
  output logic [7:0]        status
);

`ifdef FILTER_CTRL_SEQ_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] STALL_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
`else
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  // The stall limit has no effect without the timeout feature.
  localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

  localparam logic [X_W-1:0] X_LAST        = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0] Y_LAST        = Y_W'(IMG_H - 1);
  localparam logic           FIRST_IS_LAST = (IMG_W == 1) && (IMG_H == 1);

  state_t     state;
  logic       start_q;
  logic       done_flag;
  logic       abort_flag;
  logic [3:0] frame_cnt;
`ifdef FILTER_CTRL_SEQ_TIMEOUT_EN
  logic             err_flag;
  logic [CNT_W-1:0] stall_cnt;
`endif

  logic           start_pulse;
  logic           abort_req;
  logic           xfer;
  logic [X_W-1:0] next_x;
  logic [Y_W-1:0] next_y;
  logic           next_last;
  logic [3:0]     unused_ctrl;

  assign start_pulse = ctrl_in[0] & ~start_q;
  assign abort_req   = ctrl_in[7];
  assign xfer        = pix_valid & pix_ready;
  assign unused_ctrl = ctrl_in[6:3];

  // Raster position of the beat that follows the current one.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    next_x = pix_x + X_W'(1);
    next_y = pix_y;
    if (pix_x == X_LAST) begin
      next_x = '0;
      next_y = pix_y + Y_W'(1);
    end
    next_last = (next_x == X_LAST) && (next_y == Y_LAST);
  end

  // Control FSM, coordinate counters and sticky status, all registered.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values.
    if (!reset_n) begin
      state      <= IDLE;
      start_q    <= 1'b0;
      pix_valid  <= 1'b0;
      pix_last   <= 1'b0;
      pix_addr   <= '0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_mode   <= 2'b00;
      done_flag  <= 1'b0;
      abort_flag <= 1'b0;
      frame_cnt  <= 4'd0;
`ifdef FILTER_CTRL_SEQ_TIMEOUT_EN
      err_flag   <= 1'b0;
      stall_cnt  <= '0;
`endif
    end else begin
      start_q <= ctrl_in[0];
      case (state)
        RUN: begin
          if (abort_req) begin
            // Abort beats any transfer. The coordinates freeze where they are.
            state      <= IDLE;
            pix_valid  <= 1'b0;
            pix_last   <= 1'b0;
            abort_flag <= 1'b1;
          end else if (xfer) begin
`ifdef FILTER_CTRL_SEQ_TIMEOUT_EN
            stall_cnt <= '0;
`endif
            if (pix_last) begin
              state     <= DONE;
              pix_valid <= 1'b0;
              pix_last  <= 1'b0;
              done_flag <= 1'b1;
              frame_cnt <= frame_cnt + 4'd1;
            end else begin
              pix_x    <= next_x;
              pix_y    <= next_y;
              pix_addr <= pix_addr + ADDR_W'(1);
              pix_last <= next_last;
            end
          end
`ifdef FILTER_CTRL_SEQ_TIMEOUT_EN
          else if (stall_cnt == STALL_LIMIT) begin
            state     <= ERR;
            pix_valid <= 1'b0;
            pix_last  <= 1'b0;
            err_flag  <= 1'b1;
          end else begin
            stall_cnt <= stall_cnt + CNT_W'(1);
          end
`endif
        end
        default: begin
          // IDLE, DONE and ERR all accept a fresh start edge unless abort is held.
          if (start_pulse && !abort_req) begin
            state      <= RUN;
            pix_valid  <= 1'b1;
            pix_last   <= FIRST_IS_LAST;
            pix_addr   <= '0;
            pix_x      <= '0;
            pix_y      <= '0;
            pix_mode   <= ctrl_in[2:1];
            done_flag  <= 1'b0;
            abort_flag <= 1'b0;
`ifdef FILTER_CTRL_SEQ_TIMEOUT_EN
            err_flag   <= 1'b0;
            stall_cnt  <= '0;
`endif
          end
        end
      endcase
    end
  end

  // busy is exactly "in RUN", which is exactly when pix_valid is high.
`ifdef FILTER_CTRL_SEQ_TIMEOUT_EN
  assign status = {frame_cnt, abort_flag, err_flag, done_flag, pix_valid};
`else
  assign status = {frame_cnt, abort_flag, 1'b0, done_flag, pix_valid};
`endif

endmodule

// File: tb/tb_filter_ctrl_seq.sv
// tb_filter_ctrl_seq: self-checking bench for filter_ctrl_seq on a 4x2 raster.
// A frame-level model tracks the beat index, flags and frame count.
// The DUT outputs are compared against it on every falling edge.
module tb_filter_ctrl_seq;
  localparam int IMG_W          = 4;
  localparam int IMG_H          = 2;
  localparam int X_W            = 2;
  localparam int Y_W            = 1;
  localparam int ADDR_W         = 3;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int N_PIX          = IMG_W * IMG_H;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [7:0]        ctrl_in = 8'h00;
  logic              pix_ready = 1'b0;
  logic              pix_valid;
  logic [ADDR_W-1:0] pix_addr;
  logic [X_W-1:0]    pix_x;
  logic [Y_W-1:0]    pix_y;
  logic              pix_last;
  logic [1:0]        pix_mode;
  logic [7:0]        status;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  filter_ctrl_seq #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .X_W(X_W), .Y_W(Y_W),
    .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ctrl_in(ctrl_in),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_addr(pix_addr),
    .pix_x(pix_x), .pix_y(pix_y), .pix_last(pix_last),
    .pix_mode(pix_mode), .status(status)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the frame. m_k is the index of the beat on offer.
  bit         m_run, m_done, m_abort, m_err, m_prev;
  int         m_k, m_stall, m_fc;
  logic [1:0] m_mode;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_run = 0; m_done = 0; m_abort = 0; m_err = 0; m_prev = 0;
      m_k = 0; m_stall = 0; m_fc = 0; m_mode = 2'b00;
    end else begin
      if (!m_run) begin
        if (ctrl_in[0] && !m_prev && !ctrl_in[7]) begin
          m_run = 1; m_k = 0; m_mode = ctrl_in[2:1];
          m_done = 0; m_abort = 0; m_err = 0; m_stall = 0;
        end
      end else if (ctrl_in[7]) begin
        m_run = 0; m_abort = 1;
      end else if (pix_ready) begin
        m_stall = 0;
        if (m_k == N_PIX - 1) begin
          m_run = 0; m_done = 1; m_fc = (m_fc + 1) % 16;
        end else begin
          m_k++;
        end
      end else begin
        m_stall++;
`ifdef FILTER_CTRL_SEQ_TIMEOUT_EN
        if (m_stall == TIMEOUT_CYCLES) begin
          m_run = 0; m_err = 1;
        end
`endif
      end
      m_prev = ctrl_in[0];
    end
  end

  // Per-cycle comparison against the model, plus a log of delivered beats.
  int         n_xfer = 0;
  logic [7:0] log_addr [64];
  logic [7:0] log_x    [64];
  logic [7:0] log_y    [64];
  logic       log_last [64];

  always @(negedge clk) begin
    logic [7:0] exp_status;
    if (reset_n) begin
      exp_status = {m_fc[3:0], m_abort, m_err, m_done, m_run};
      check("valid", pix_valid, m_run);
      check("status", status, exp_status);
      check("mode", pix_mode, m_mode);
      if (m_run) begin
        check("addr", pix_addr, m_k);
        check("x", pix_x, m_k % IMG_W);
        check("y", pix_y, m_k / IMG_W);
        check("last", pix_last, m_k == N_PIX - 1);
      end
      if (pix_valid && pix_ready) begin
        if (n_xfer < 64) begin
          log_addr[n_xfer] = 8'(pix_addr);
          log_x[n_xfer]    = 8'(pix_x);
          log_y[n_xfer]    = 8'(pix_y);
          log_last[n_xfer] = pix_last;
        end
        n_xfer++;
      end
    end
  end

  // Advance n clock edges, leaving inputs to change just after the edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Wait for the frame to end, bounded. Optionally drive random ready.
  task automatic wait_frame(input string name, input bit rand_ready);
    int c;
    c = 0;
    while (pix_valid && c < 200) begin
      if (rand_ready) pix_ready = 1'($urandom_range(0, 1));
      tick(1);
      c++;
    end
    check({name, "_ends"}, pix_valid, 0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_valid"}, pix_valid, 0);
    check({name, "_last"}, pix_last, 0);
    check({name, "_addr"}, pix_addr, 0);
    check({name, "_x"}, pix_x, 0);
    check({name, "_y"}, pix_y, 0);
    check({name, "_mode"}, pix_mode, 0);
    check({name, "_status"}, status, 8'h00);
  endtask

  initial begin
    #1;
    check_all_zero("reset");
    tick(2);
    reset_n = 1'b1;
    tick(1);

    // Basic frame with ready held high, mode 2.
    pix_ready = 1'b1;
    n_xfer = 0;
    ctrl_in = 8'h05;
    tick(1);
    check("t1_latency_valid", pix_valid, 1);
    check("t1_first_addr", pix_addr, 0);
    wait_frame("t1", 0);
    check("t1_beats", n_xfer, 8);
    check("t1_addr7", log_addr[7], 7);
    check("t1_x5", log_x[5], 1);
    check("t1_y5", log_y[5], 1);
    check("t1_y3", log_y[3], 0);
    check("t1_last7", log_last[7], 1);
    check("t1_last6", log_last[6], 0);
    check("t1_mode", pix_mode, 2);
    check("t1_status", status, 8'h12);

    // A held start level must not retrigger.
    n_xfer = 0;
    ctrl_in = 8'h01;
    tick(50);
    check("t2_no_retrigger", n_xfer, 0);
    check("t2_status_hold", status, 8'h12);
    ctrl_in = 8'h00;
    tick(1);
    ctrl_in = 8'h01;
    tick(1);
    wait_frame("t2", 0);
    check("t2_beats", n_xfer, 8);
    check("t2_status", status, 8'h22);

    // Random backpressure: every beat is delivered once, in order.
    ctrl_in = 8'h00;
    tick(1);
    n_xfer = 0;
    ctrl_in = 8'h03;
    tick(1);
    wait_frame("t3", 1);
    check("t3_beats", n_xfer, 8);
    for (int i = 0; i < N_PIX; i++) check("t3_order", log_addr[i], i);
    check("t3_status", status, 8'h32);

    // Asynchronous reset in the middle of a frame.
    ctrl_in = 8'h00;
    tick(1);
    ctrl_in = 8'h07;
    pix_ready = 1'b1;
    tick(3);
    check("t4_pre_addr", pix_addr, 2);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    ctrl_in = 8'h00;
    #1;
    check_all_zero("t4_midreset");
    tick(2);
    reset_n = 1'b1;
    tick(1);

    // Abort after three transfers.
    n_xfer = 0;
    ctrl_in = 8'h01;
    tick(1);
    tick(3);
    ctrl_in = 8'h81;
    pix_ready = 1'b0;
    tick(1);
    check("t5_abort_valid", pix_valid, 0);
    check("t5_abort_status", status, 8'h08);
    check("t5_abort_beats", n_xfer, 3);
    ctrl_in = 8'h00;
    pix_ready = 1'b1;
    tick(1);
    ctrl_in = 8'h05;
    tick(1);
    check("t5_restart_addr", pix_addr, 0);
    wait_frame("t5", 0);
    check("t5_status", status, 8'h12);

    // Abort and start together from DONE: abort wins, start edge is consumed.
    ctrl_in = 8'h00;
    tick(1);
    ctrl_in = 8'h81;
    tick(1);
    check("t6_abort_start_valid", pix_valid, 0);
    check("t6_abort_start_status", status, 8'h12);
    ctrl_in = 8'h01;
    tick(2);
    check("t6_no_late_start", pix_valid, 0);
    ctrl_in = 8'h00;
    tick(1);
    ctrl_in = 8'h01;
    tick(1);
    check("t6_start", pix_valid, 1);
    wait_frame("t6", 0);
    check("t6_status", status, 8'h22);

`ifdef FILTER_CTRL_SEQ_TIMEOUT_EN
    // Stall timeout from a clean reset.
    reset_n = 1'b0;
    ctrl_in = 8'h00;
    pix_ready = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
    ctrl_in = 8'h01;
    tick(1);
    tick(15);
    check("t7_still_waiting", pix_valid, 1);
    check("t7_busy_status", status, 8'h01);
    tick(1);
    check("t7_timeout_valid", pix_valid, 0);
    check("t7_timeout_status", status, 8'h04);
    ctrl_in = 8'h00;
    pix_ready = 1'b1;
    tick(1);
    ctrl_in = 8'h05;
    tick(1);
    check("t7_err_cleared", status, 8'h01);
    wait_frame("t7", 0);
    check("t7_status", status, 8'h12);
`endif

    tick(2);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Last-resort guard so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
